ahb2apb_bridge_p: RTL

Parametrised AHB-Lite-slave to APB3-master bridge, the next generation of the team's AHB–APB bridge. It adds configurable address/data width, N decoded APB slaves, PREADY wait states, PSLVERR propagation to a two-cycle AHB ERROR response, decode-miss errors and a PREADY timeout. It sits between the AHB interconnect and the peripheral APB segment, one outstanding transfer at a time.

---
 rtl/ahb2apb_pkg.sv | 20 ++
 rtl/ahb2apb_decoder.sv | 26 ++
 rtl/ahb2apb_bridge_p.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared types and constants for the AHB-Lite to APB3 bridge
//   state_e      : bridge FSM states
//   HRESP_*      : AHB response codes driven on hresp
//   HTRANS_*     : AHB transfer type codes seen on htrans
package ahb2apb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
endpackage

// File: rtl/ahb2apb_decoder.sv
// ahb2apb_decoder: maps an AHB address onto one of NUM_SLV APB slave regions
//   i_addr : AHB address
//   o_hit  : address falls inside the APB window and on an existing slave
//   o_idx  : slave index (meaningful only when o_hit)
//   o_sel  : one-hot slave select, all zero on a miss
module ahb2apb_decoder #(
  parameter int              AW        = 32,
  parameter int              NUM_SLV   = 4,
  parameter int              SLV_AW    = 12,
  parameter int              IW        = 2,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h8000_0000
) (
  input  logic [AW-1:0]      i_addr,
  output logic               o_hit,
  output logic [IW-1:0]      o_idx,
  output logic [NUM_SLV-1:0] o_sel
);
  logic [AW-1:0] w_off;
  logic [AW-1:0] w_idx;
  assign w_off = i_addr - BASE_ADDR;
  assign w_idx = w_off >> SLV_AW;
  // Below the base the subtraction wraps, so the >= test is needed on its own.
  assign o_hit = (i_addr >= BASE_ADDR) && (w_idx < AW'(NUM_SLV));
  assign o_idx = w_idx[IW-1:0];
  assign o_sel = o_hit ? NUM_SLV'(1) << o_idx : '0;
endmodule

// File: rtl/ahb2apb_bridge_p.sv
// ahb2apb_bridge_p: AHB-Lite slave to APB3 master bridge, one transfer in flight
//   hclk/hresetn            : clock, synchronous active-low reset
//   htrans/haddr/hwrite     : AHB address phase, hreadyin bus ready
//   hwdata                  : AHB write data (data phase)
//   hreadyout/hresp/hrdata  : AHB response
//   pselx/penable/pwrite    : APB control, registered
//   paddr/pwdata            : APB address / write data, registered
//   prdata/pready/pslverr   : per-slave APB responses, slave i in lane i
module ahb2apb_bridge_p
  import ahb2apb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            NUM_SLV   = 4,
  parameter logic [AW-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int            SLV_AW    = 12,
  parameter int            TIMEOUT   = 256
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hwrite,
  input  logic                  hreadyin,
  input  logic [1:0]            htrans,
  input  logic [AW-1:0]         haddr,
  input  logic [DW-1:0]         hwdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DW-1:0]         hrdata,
  output logic [NUM_SLV-1:0]    pselx,
  output logic                  penable,
  output logic                  pwrite,
  output logic [AW-1:0]         paddr,
  output logic [DW-1:0]         pwdata,
  input  logic [NUM_SLV*DW-1:0] prdata,
  input  logic [NUM_SLV-1:0]    pready,
  input  logic [NUM_SLV-1:0]    pslverr
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  state_e               r_state;
  state_e               w_nxt;
  state_e               w_acc_st;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx;
  logic [NUM_SLV-1:0]   w_sel;
  logic                 w_hit;
  logic [CW-1:0]        r_cnt;
  logic [NUM_SLV-1:0]   r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [AW-1:0]        r_paddr;
  logic [DW-1:0]        r_pwdata;
  logic                 w_accept;
  logic                 w_rdy;
  logic                 w_err;
  logic                 w_to;
  logic                 w_done;
  ahb2apb_decoder #(
    .AW(AW), .NUM_SLV(NUM_SLV), .SLV_AW(SLV_AW), .IW(IW), .BASE_ADDR(BASE_ADDR)
  ) u_dec (
    .i_addr(haddr), .o_hit(w_hit), .o_idx(w_idx), .o_sel(w_sel)
  );
  assign w_rdy    = pready[r_idx];
  assign w_err    = pslverr[r_idx];
  assign w_to     = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign w_done   = (r_state == ST_ACCESS) && w_rdy && !w_err;
  // ERR2 reports ready but must not start a transfer: the master is cancelling.
  assign w_accept = hreadyin && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) &&
                    hreadyout && (r_state != ST_ERR2);
  assign w_acc_st = !w_hit ? ST_ERR1 : hwrite ? ST_WDATA : ST_SETUP;
  always_ff @(posedge hclk) begin
    if (!hresetn) r_state <= ST_IDLE;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:   w_nxt = w_accept ? w_acc_st : ST_IDLE;
      ST_WDATA:  w_nxt = ST_SETUP;
      ST_SETUP:  w_nxt = ST_ACCESS;
      ST_ACCESS: w_nxt = !w_rdy ? (w_to ? ST_ERR1 : ST_ACCESS) :
                         w_err ? ST_ERR1 : w_accept ? w_acc_st : ST_IDLE;
      ST_ERR1:   w_nxt = ST_ERR2;
      default:   w_nxt = ST_IDLE;
    endcase
  end
  always_comb begin
    hreadyout = (r_state == ST_IDLE) || (r_state == ST_ERR2) || w_done;
    hresp     = (r_state == ST_ERR1 || r_state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    hrdata    = w_done ? prdata[r_idx*DW +: DW] : '0;
  end
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      // A freshly accepted transfer selects from the decoder; WDATA->SETUP and ACCESS hold use the latched index.
      r_psel    <= (w_nxt == ST_SETUP || w_nxt == ST_ACCESS) ?
                   (w_accept ? w_sel : NUM_SLV'(1) << r_idx) : '0;
      r_penable <= w_nxt == ST_ACCESS;
      if (w_accept && w_hit) begin
        r_idx    <= w_idx;
        r_paddr  <= haddr;
        r_pwrite <= hwrite;
      end
      if (r_state == ST_WDATA) r_pwdata <= hwdata;
      r_cnt     <= (r_state == ST_ACCESS && w_nxt == ST_ACCESS) ? r_cnt + CW'(1) : '0;
    end
  end
  assign pselx   = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
endmodule
